// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared encodings for the
// unified memory port arbiter.
package mem_port_arbiter_pkg;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } arb_state_t;

  localparam logic OWN_CORE = 1'b0;
  localparam logic OWN_DMA  = 1'b1;
  localparam int   CNT_W    = 4;

  function automatic logic [CNT_W-1:0] lat_load(
    int lat
  );
    return CNT_W'(lat - 1);
  endfunction
endpackage

// File: rtl/rr_arbiter_2.sv
// rr_arbiter_2: two-way round-robin pick; on a tie
// the requester that was not served last wins.
module rr_arbiter_2
  import mem_port_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic gnt_valid,
  output logic gnt
);
  assign gnt_valid = req0 | req1;
  assign gnt = (req0 & req1) ? ~last
             : (req1 ? OWN_DMA : OWN_CORE);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single-port memory
// between core and DMA, one fixed-latency access at a time.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_ack,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              owner
);
  localparam logic [CNT_W-1:0] LAT_LD =
    lat_load(MEM_LAT);

  arb_state_t        state;
  arb_state_t        state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              gnt_valid;
  logic              gnt;
  logic              owner_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              grant;

  rr_arbiter_2 u_rr (
    .req0      (core_req),
    .req1      (dma_req),
    .last      (owner_q),
    .gnt_valid (gnt_valid),
    .gnt       (gnt)
  );

  assign grant = (state == S_IDLE) & gnt_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (gnt_valid) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = (MEM_LAT == 1) ? S_RESP
                                          : S_WAIT;
      S_WAIT:  if (cnt == CNT_W'(1))
                 state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // counter reaches zero on the edge into RESP
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (state == S_ISSUE)
      cnt <= LAT_LD;
    else if (state == S_WAIT)
      cnt <= cnt - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q <= OWN_DMA;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (grant) begin
      owner_q <= gnt;
      we_q    <= gnt ? dma_we    : core_we;
      addr_q  <= gnt ? dma_addr  : core_addr;
      wdata_q <= gnt ? dma_wdata : core_wdata;
    end
  end

  always_comb begin
    mem_en     = 1'b0;
    core_ack   = 1'b0;
    dma_ack    = 1'b0;
    core_rdata = '0;
    dma_rdata  = '0;
    unique case (state)
      S_ISSUE: mem_en = 1'b1;
      S_RESP: begin
        if (owner_q == OWN_DMA) begin
          dma_ack   = 1'b1;
          dma_rdata = mem_rdata;
        end else begin
          core_ack   = 1'b1;
          core_rdata = mem_rdata;
        end
      end
      default: ;
    endcase
  end

  assign mem_we    = mem_en & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign owner     = owner_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: three arbiters (MEM_LAT 2, 1, 15)
// against a transaction-level schedule model.
module tb_mem_port_arbiter;
  localparam int N = 3;
  localparam logic [31:0] FILL = 32'h0BAD_F00D;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        core_req   [N];
  logic        core_we    [N];
  logic [31:0] core_addr  [N];
  logic [31:0] core_wdata [N];
  logic [31:0] core_rdata [N];
  logic        core_ack   [N];
  logic        dma_req    [N];
  logic        dma_we     [N];
  logic [31:0] dma_addr   [N];
  logic [31:0] dma_wdata  [N];
  logic [31:0] dma_rdata  [N];
  logic        dma_ack    [N];
  logic        mem_en     [N];
  logic        mem_we     [N];
  logic [31:0] mem_addr   [N];
  logic [31:0] mem_wdata  [N];
  logic [31:0] mem_rdata  [N];
  logic        owner      [N];

  logic [31:0] mem  [N][1024];
  logic [31:0] pipe [N][16];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // model state
  int          free_e [N];
  int          iss_c  [N];
  int          ack_c  [N];
  bit          own_m  [N];
  bit          who    [N];
  bit          ex_we  [N];
  logic [31:0] ex_addr[N];
  logic [31:0] ex_wd  [N];
  logic [31:0] ex_rd  [N];
  bit          ex_rok [N];
  bit          outst  [N][2];
  logic [31:0] refm   [N][1024];
  bit          refv   [N][1024];
  int          n_en   [N];
  int          n_ack  [N];
  int          n_iss  [N];

  function automatic int lat_of(int k);
    return (k == 0) ? 2 : (k == 1) ? 1 : 15;
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int L = (g == 0) ? 2 : (g == 1) ? 1 : 15;
    mem_port_arbiter #(
      .ADDR_W (32),
      .DATA_W (32),
      .MEM_LAT(L)
    ) dut (
      .clk        (clk),
      .reset      (reset),
      .core_req   (core_req[g]),
      .core_we    (core_we[g]),
      .core_addr  (core_addr[g]),
      .core_wdata (core_wdata[g]),
      .core_rdata (core_rdata[g]),
      .core_ack   (core_ack[g]),
      .dma_req    (dma_req[g]),
      .dma_we     (dma_we[g]),
      .dma_addr   (dma_addr[g]),
      .dma_wdata  (dma_wdata[g]),
      .dma_rdata  (dma_rdata[g]),
      .dma_ack    (dma_ack[g]),
      .mem_en     (mem_en[g]),
      .mem_we     (mem_we[g]),
      .mem_addr   (mem_addr[g]),
      .mem_wdata  (mem_wdata[g]),
      .mem_rdata  (mem_rdata[g]),
      .owner      (owner[g])
    );
    assign mem_rdata[g] = pipe[g][L-1];
  end

  always @(posedge clk) cyc <= cyc + 1;

  // memory: write at the strobe, read data after MEM_LAT cycles
  always @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (mem_en[k] && mem_we[k])
        mem[k][mem_addr[k][11:2]] <= mem_wdata[k];
      pipe[k][0] <= mem_en[k] ? mem[k][mem_addr[k][11:2]]
                              : FILL;
      for (int i = 1; i < 16; i++)
        pipe[k][i] <= pipe[k][i-1];
    end
  end

  task automatic raise(int k, int r, bit we,
                       logic [31:0] a, logic [31:0] d);
    if (r == 0) begin
      core_req[k] = 1'b1; core_we[k] = we;
      core_addr[k] = a;   core_wdata[k] = d;
    end else begin
      dma_req[k] = 1'b1;  dma_we[k] = we;
      dma_addr[k] = a;    dma_wdata[k] = d;
    end
  endtask

  task automatic drop(int k, int r);
    if (r == 0) core_req[k] = 1'b0;
    else        dma_req[k]  = 1'b0;
  endtask

  function automatic logic [31:0] rnd_addr();
    return 32'($urandom_range(15)) << 2;
  endfunction

  function automatic bit idle(int k);
    return !core_req[k] && !dma_req[k] &&
           !outst[k][0] && !outst[k][1] &&
           cyc >= free_e[k];
  endfunction

  task automatic assert_reset();
    reset = 1'b1;
    for (int k = 0; k < N; k++) begin
      core_req[k] = 1'b0;
      dma_req[k]  = 1'b0;
      free_e[k]   = 0;
      iss_c[k]    = -100;
      ack_c[k]    = -100;
      own_m[k]    = 1'b1;
      outst[k][0] = 1'b0;
      outst[k][1] = 1'b0;
    end
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // one clock of instance k: schedule model, compare, requesters
  task automatic tick(int k, int raise_pct,
                      int keep_pct, int drop_pct);
    int c;
    int L;
    bit w;
    bit a;
    bit rq;
    logic [31:0] rd;
    logic [9:0]  ix;
    L = lat_of(k);
    @(posedge clk);
    #1;
    c = cyc;
    if (!reset && c >= free_e[k] &&
        (core_req[k] || dma_req[k])) begin
      w = (core_req[k] && dma_req[k]) ? !own_m[k]
                                      : dma_req[k];
      own_m[k]   = w;
      who[k]     = w;
      iss_c[k]   = c;
      ack_c[k]   = c + L;
      free_e[k]  = c + L + 2;
      ex_we[k]   = w ? dma_we[k]    : core_we[k];
      ex_addr[k] = w ? dma_addr[k]  : core_addr[k];
      ex_wd[k]   = w ? dma_wdata[k] : core_wdata[k];
      ix = ex_addr[k][11:2];
      ex_rok[k] = !ex_we[k] && refv[k][ix];
      ex_rd[k]  = refm[k][ix];
      if (ex_we[k]) begin
        refm[k][ix] = ex_wd[k];
        refv[k][ix] = 1'b1;
      end
      outst[k][w] = 1'b1;
      n_iss[k]++;
    end
    n_tests++;
    if (mem_en[k] !== (c == iss_c[k])) begin
      n_fail++;
      $display("FAIL mem_en inst%0d cyc%0d got %b exp %b",
               k, c, mem_en[k], c == iss_c[k]);
    end
    if (c == iss_c[k]) begin
      n_tests++;
      if (mem_addr[k] !== ex_addr[k] ||
          mem_we[k] !== ex_we[k] ||
          (ex_we[k] && mem_wdata[k] !== ex_wd[k])) begin
        n_fail++;
        $display("FAIL issue inst%0d cyc%0d got a=%h we=%b d=%h exp a=%h we=%b d=%h",
                 k, c, mem_addr[k], mem_we[k], mem_wdata[k],
                 ex_addr[k], ex_we[k], ex_wd[k]);
      end
    end
    n_tests++;
    if (core_ack[k] !== (c == ack_c[k] && !who[k]) ||
        dma_ack[k]  !== (c == ack_c[k] &&  who[k])) begin
      n_fail++;
      $display("FAIL ack inst%0d cyc%0d got c=%b d=%b exp c=%b d=%b",
               k, c, core_ack[k], dma_ack[k],
               c == ack_c[k] && !who[k],
               c == ack_c[k] && who[k]);
    end
    if (c == ack_c[k] && ex_rok[k]) begin
      rd = who[k] ? dma_rdata[k] : core_rdata[k];
      n_tests++;
      if (rd !== ex_rd[k]) begin
        n_fail++;
        $display("FAIL rdata inst%0d cyc%0d got %h exp %h",
                 k, c, rd, ex_rd[k]);
      end
    end
    n_tests++;
    if (owner[k] !== own_m[k]) begin
      n_fail++;
      $display("FAIL owner inst%0d cyc%0d got %b exp %b",
               k, c, owner[k], own_m[k]);
    end
    if (mem_en[k]) n_en[k]++;
    if (core_ack[k] || dma_ack[k]) n_ack[k]++;
    for (int r = 0; r < 2; r++) begin
      a  = (c == ack_c[k]) && (who[k] == r[0]);
      rq = (r == 0) ? core_req[k] : dma_req[k];
      if (a) begin
        outst[k][r] = 1'b0;
        if (rq && $urandom_range(99) < keep_pct)
          raise(k, r, $urandom_range(1) == 1,
                rnd_addr(), $urandom());
        else
          drop(k, r);
      end else if (rq && outst[k][r] &&
                   $urandom_range(99) < drop_pct) begin
        drop(k, r);
      end else if (!rq && !outst[k][r] &&
                   $urandom_range(99) < raise_pct) begin
        raise(k, r, $urandom_range(1) == 1,
              rnd_addr(), $urandom());
      end
    end
  endtask

  task automatic drain(int k);
    int n;
    n = 0;
    while (!idle(k) && n < 100) begin
      tick(k, 0, 0, 0);
      n++;
    end
    n_tests++;
    if (!idle(k)) begin
      n_fail++;
      $display("FAIL drain inst%0d got busy exp idle", k);
    end
  endtask

  task automatic test_reset();
    assert_reset();
    #1;
    for (int k = 0; k < N; k++) begin
      n_tests++;
      if (mem_en[k] !== 1'b0 || mem_we[k] !== 1'b0 ||
          core_ack[k] !== 1'b0 || dma_ack[k] !== 1'b0 ||
          mem_addr[k] !== 32'h0 || mem_wdata[k] !== 32'h0 ||
          core_rdata[k] !== 32'h0 || dma_rdata[k] !== 32'h0 ||
          owner[k] !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_vals inst%0d got en=%b own=%b a=%h exp en=0 own=1 a=0",
                 k, mem_en[k], owner[k], mem_addr[k]);
      end
    end
    release_reset();
    raise(0, 0, 0, 32'h44, 32'h0);
    tick(0, 0, 0, 0);
    n_tests++;
    if (mem_en[0] !== 1'b1 || owner[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL pre_reset_issue got en=%b own=%b exp en=1 own=0",
               mem_en[0], owner[0]);
    end
    assert_reset();
    #1;
    n_tests++;
    if (mem_en[0] !== 1'b0 || owner[0] !== 1'b1 ||
        mem_addr[0] !== 32'h0 || core_ack[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset got en=%b own=%b a=%h exp en=0 own=1 a=0",
               mem_en[0], owner[0], mem_addr[0]);
    end
    release_reset();
  endtask

  task automatic test_tie();
    int c0;
    int ca;
    int da;
    for (int rep = 0; rep < 2; rep++) begin
      raise(0, 0, 0, 32'h80, 32'h0);
      raise(0, 1, 0, 32'h84, 32'h0);
      c0 = 0;
      ca = -1;
      da = -1;
      for (int i = 0; i < 10; i++) begin
        tick(0, 0, 0, 0);
        if (i == 0) c0 = cyc;
        if (core_ack[0] && ca < 0) ca = cyc - c0;
        if (dma_ack[0] && da < 0)  da = cyc - c0;
        if (i == 0) begin
          n_tests++;
          if (owner[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL tie_owner0 rep%0d got %b exp 0",
                     rep, owner[0]);
          end
        end
        if (i == 4) begin
          n_tests++;
          if (owner[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL tie_owner1 rep%0d got %b exp 1",
                     rep, owner[0]);
          end
        end
      end
      n_tests++;
      if (ca != 2 || da != 6) begin
        n_fail++;
        $display("FAIL tie_order rep%0d got core=%0d dma=%0d exp core=2 dma=6",
                 rep, ca, da);
      end
    end
  endtask

  task automatic test_core_read();
    raise(0, 1, 1, 32'h40, 32'hDEAD_BEEF);
    drain(0);
    raise(0, 0, 0, 32'h40, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick(0, 0, 0, 0);
      n_tests++;
      if (core_ack[0] !== (i == 2)) begin
        n_fail++;
        $display("FAIL read_ack step%0d got %b exp %b",
                 i, core_ack[0], i == 2);
      end
      if (i == 0) begin
        n_tests++;
        if (mem_en[0] !== 1'b1 || mem_we[0] !== 1'b0 ||
            mem_addr[0] !== 32'h40) begin
          n_fail++;
          $display("FAIL read_issue got en=%b we=%b a=%h exp en=1 we=0 a=40",
                   mem_en[0], mem_we[0], mem_addr[0]);
        end
      end
      if (i == 2) begin
        n_tests++;
        if (core_rdata[0] !== 32'hDEAD_BEEF) begin
          n_fail++;
          $display("FAIL read_data got %h exp deadbeef",
                   core_rdata[0]);
        end
      end
    end
    drain(0);
  endtask

  task automatic test_dma_write_core_read();
    bit got;
    raise(0, 1, 1, 32'h100, 32'h1234_5678);
    tick(0, 0, 0, 0);
    n_tests++;
    if (mem_en[0] !== 1'b1 || mem_we[0] !== 1'b1 ||
        mem_addr[0] !== 32'h100 ||
        mem_wdata[0] !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL dma_write got en=%b we=%b a=%h d=%h exp en=1 we=1 a=100 d=12345678",
               mem_en[0], mem_we[0], mem_addr[0], mem_wdata[0]);
    end
    raise(0, 0, 0, 32'h100, 32'h0);
    got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      tick(0, 0, 0, 0);
      if (core_ack[0]) begin
        got = 1'b1;
        n_tests++;
        if (core_rdata[0] !== 32'h1234_5678) begin
          n_fail++;
          $display("FAIL raw_data got %h exp 12345678",
                   core_rdata[0]);
        end
      end
    end
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL raw_timeout got no ack exp ack");
    end
    drain(0);
  endtask

  task automatic test_reset_in_wait();
    int nack;
    int c0;
    int ca;
    raise(2, 0, 0, 32'h48, 32'h0);
    repeat (3) tick(2, 0, 0, 0);
    assert_reset();
    #1;
    n_tests++;
    if (mem_en[2] !== 1'b0 || core_ack[2] !== 1'b0 ||
        owner[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_reset got en=%b ack=%b own=%b exp 0 0 1",
               mem_en[2], core_ack[2], owner[2]);
    end
    release_reset();
    nack = 0;
    repeat (20) begin
      tick(2, 0, 0, 0);
      if (core_ack[2] || dma_ack[2]) nack++;
    end
    n_tests++;
    if (nack != 0) begin
      n_fail++;
      $display("FAIL ghost_ack got %0d exp 0", nack);
    end
    raise(2, 0, 1, 32'h48, 32'hCAFE_0001);
    c0 = -1;
    ca = -1;
    for (int i = 0; i < 24; i++) begin
      tick(2, 0, 0, 0);
      if (mem_en[2] && c0 < 0)   c0 = cyc;
      if (core_ack[2] && ca < 0) ca = cyc;
    end
    n_tests++;
    if (c0 < 0 || ca - c0 != 15) begin
      n_fail++;
      $display("FAIL rerequest got en@%0d ack@%0d exp gap 15",
               c0, ca);
    end
  endtask

  task automatic test_sweep();
    for (int k = 0; k < N; k++) begin
      n_en[k]  = 0;
      n_ack[k] = 0;
      n_iss[k] = 0;
      repeat ((k == 2) ? 500 : 300) tick(k, 30, 40, 5);
      drain(k);
      n_tests++;
      if (n_en[k] != n_ack[k] || n_ack[k] != n_iss[k] ||
          n_iss[k] < 5) begin
        n_fail++;
        $display("FAIL sweep inst%0d got en=%0d ack=%0d exp both=%0d",
                 k, n_en[k], n_ack[k], n_iss[k]);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      core_we[k] = 1'b0; core_addr[k] = '0; core_wdata[k] = '0;
      dma_we[k]  = 1'b0; dma_addr[k]  = '0; dma_wdata[k]  = '0;
      n_en[k] = 0; n_ack[k] = 0; n_iss[k] = 0;
      for (int i = 0; i < 1024; i++) begin
        refv[k][i] = 1'b0;
        refm[k][i] = '0;
      end
    end
    test_reset();
    test_tie();
    test_core_read();
    test_dma_write_core_read();
    test_reset_in_wait();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
